// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: size codes, FSM states and the
// byte-enable, access-check and load-extension helpers.
package lsu_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_t;

  function automatic logic [3:0] lsu_byte_en(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      LSU_B, LSU_BU: lsu_byte_en = 4'b0001 << off;
      LSU_H, LSU_HU: lsu_byte_en = 4'b0011 << off;
      default:       lsu_byte_en = 4'b1111;
    endcase
  endfunction

  // Misaligned halves/words, undefined size codes and unsigned stores all fault.
  function automatic logic lsu_access_fault(input logic [2:0] f3, input logic [1:0] off,
                                            input logic store);
    case (f3)
      LSU_B:   lsu_access_fault = 1'b0;
      LSU_BU:  lsu_access_fault = store;
      LSU_H:   lsu_access_fault = off[0];
      LSU_HU:  lsu_access_fault = store | off[0];
      LSU_W:   lsu_access_fault = (off != 2'b00);
      default: lsu_access_fault = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] lsu_extend(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (f3)
      LSU_B:   lsu_extend = {{24{sh[7]}}, sh[7:0]};
      LSU_BU:  lsu_extend = {24'h000000, sh[7:0]};
      LSU_H:   lsu_extend = {{16{sh[15]}}, sh[15:0]};
      LSU_HU:  lsu_extend = {16'h0000, sh[15:0]};
      default: lsu_extend = word;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory port between the load/store unit (master) and the memory (slave).
interface load_store_unit_if #(parameter int WORD_SIZE = 32);

  logic                 mem_req;
  logic                 mem_we;
  logic [WORD_SIZE-1:0] mem_addr;
  logic [3:0]           mem_be;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic                 mem_gnt;
  logic                 mem_rvalid;
  logic [WORD_SIZE-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables and data replication, and
// load lane select with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_data,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  assign st_be = lsu_byte_en(st_funct3, st_off);

  // Bytes repeat on every lane and halves on both halves, so the enables alone pick the target.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign st_data[8*gi +: 8] = (st_funct3[1:0] == 2'b00) ? st_wdata[7:0] :
                                  (st_funct3[1:0] == 2'b01) ? st_wdata[8*(gi%2) +: 8] :
                                                              st_wdata[8*gi +: 8];
    end
  endgenerate

  assign ld_data = lsu_extend(ld_funct3, ld_off, ld_word);

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: captures an ALU address, runs one request/grant access on
// the data-memory port and returns extended load data with a done pulse.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_load,
  input  logic                 is_store,
  input  logic [2:0]           funct3,
  input  logic [WORD_SIZE-1:0] addr,
  input  logic [WORD_SIZE-1:0] wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 fault,
  output logic [WORD_SIZE-1:0] rdata,
  load_store_unit_if.master    mem
);

  lsu_state_t state_reg, state_next;

  logic [2:0]  funct3_reg;
  logic [1:0]  off_reg;
  logic        load_reg;
  logic        busy_reg, done_reg, fault_reg, req_reg, we_reg;
  logic [31:0] rdata_reg, mem_addr_reg, mem_wdata_reg;
  logic [3:0]  mem_be_reg;

  logic        accept, access_bad, store_only;
  logic [3:0]  st_be;
  logic [31:0] st_data, ld_data;

  // A start with both direction bits set is a load.
  assign store_only = is_store && !is_load;
  assign accept     = (state_reg == ST_IDLE) && start && (is_load || is_store);
  assign access_bad = lsu_access_fault(funct3, addr[1:0], store_only);

  lsu_align u_align (
    .st_funct3 (funct3),
    .st_off    (addr[1:0]),
    .st_wdata  (wdata),
    .st_be     (st_be),
    .st_data   (st_data),
    .ld_funct3 (funct3_reg),
    .ld_off    (off_reg),
    .ld_word   (mem.mem_rdata),
    .ld_data   (ld_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept)          state_next = access_bad ? ST_DONE : ST_REQ;
      ST_REQ:  if (mem.mem_gnt)     state_next = load_reg ? ST_WAIT : ST_DONE;
      ST_WAIT: if (mem.mem_rvalid)  state_next = ST_DONE;
      ST_DONE:                      state_next = ST_IDLE;
      default:                      state_next = ST_IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so every output leaves a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      fault_reg     <= 1'b0;
      req_reg       <= 1'b0;
      we_reg        <= 1'b0;
      funct3_reg    <= 3'b000;
      off_reg       <= 2'b00;
      load_reg      <= 1'b0;
      rdata_reg     <= '0;
      mem_addr_reg  <= '0;
      mem_be_reg    <= 4'b0000;
      mem_wdata_reg <= '0;
    end else begin
      busy_reg <= (state_next != ST_IDLE);
      done_reg <= (state_next == ST_DONE);
      req_reg  <= (state_next == ST_REQ);
      if (accept) begin
        funct3_reg <= funct3;
        off_reg    <= addr[1:0];
        load_reg   <= is_load;
        fault_reg  <= access_bad;
        if (!access_bad) begin
          mem_addr_reg  <= {addr[31:2], 2'b00};
          mem_be_reg    <= st_be;
          mem_wdata_reg <= st_data;
          we_reg        <= store_only;
        end
      end else if ((state_reg == ST_REQ) && mem.mem_gnt) begin
        we_reg <= 1'b0;
      end
      if ((state_reg == ST_WAIT) && mem.mem_rvalid) begin
        rdata_reg <= ld_data;
      end
    end
  end

  assign busy          = busy_reg;
  assign done          = done_reg;
  assign fault         = fault_reg;
  assign rdata         = rdata_reg;
  assign mem.mem_req   = req_reg;
  assign mem.mem_we    = we_reg;
  assign mem.mem_addr  = mem_addr_reg;
  assign mem.mem_be    = mem_be_reg;
  assign mem.mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: the driver plays the memory and queues
// expected completions; a negedge monitor checks every done pulse.
module tb_load_store_unit;

  typedef struct {
    logic        fault;
    logic        chk_rdata;
    logic [31:0] rdata;
    int          done_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, start, is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata;
  logic        busy, done, fault;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_txn = 0;
  logic [31:0] last_rdata = 32'h0;
  exp_t        exp_q[$];
  exp_t        mon_e;

  load_store_unit_if #(.WORD_SIZE(32)) mem_bus ();

  load_store_unit #(.WORD_SIZE(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .is_load  (is_load),
    .is_store (is_store),
    .funct3   (funct3),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .fault    (fault),
    .rdata    (rdata),
    .mem      (mem_bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: behaviour from the size/alignment rules using plain arithmetic.
  task automatic model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rw, input logic st, output logic flt,
                       output logic [3:0] be, output logic [31:0] wexp, output logic [31:0] rexp);
    int size, off;
    logic uns;
    logic [63:0] v, mask;
    uns = f3[2];
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    off = int'(a % 4);
    if (size == 0) flt = 1'b1;
    else flt = ((off % size) != 0) || (st && uns);
    be = 4'(((1 << size) - 1) << off);
    if (size == 1)      wexp = (wd & 32'hFF) * 32'h01010101;
    else if (size == 2) wexp = (wd & 32'hFFFF) * 32'h00010001;
    else                wexp = wd;
    mask = (64'd1 << (8 * size)) - 64'd1;
    v = ({32'h0, rw} >> (8 * off)) & mask;
    if (!uns && size > 0 && size < 4 && v[8*size-1]) v = v | ~mask;
    rexp = v[31:0];
  endtask

  // Caller is at a negedge with the DUT idle; returns in the same situation.
  task automatic access(input logic il, input logic si, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rw,
                        input int gd, input int rd, input bit siw, input bit riw);
    logic flt;
    logic [3:0] be;
    logic [31:0] wexp, rexp;
    exp_t e;
    int n;
    model(f3, a, wd, rw, !il, flt, be, wexp, rexp);
    start = 1'b1; is_load = il; is_store = si; funct3 = f3; addr = a; wdata = wd;
    if ((il || si) && !riw) begin
      e.fault = flt;
      e.chk_rdata = il && !flt;
      e.rdata = rexp;
      e.done_cyc = cyc + (flt ? 1 : (il ? 3 + gd + rd : 2 + gd));
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0; is_load = 1'($urandom_range(0, 1)); is_store = 1'($urandom_range(0, 1));
    funct3 = 3'($urandom_range(0, 7)); addr = $urandom; wdata = $urandom;
    if (!il && !si) begin
      check("nop_busy", busy, 0);
      check("nop_req", mem_bus.mem_req, 0);
      return;
    end
    if (flt) begin
      check("fault_noreq", mem_bus.mem_req, 0);
    end else begin
      for (int i = 0; i <= gd; i++) begin
        check("req", mem_bus.mem_req, 1);
        check("we", mem_bus.mem_we, !il);
        check("mem_addr", mem_bus.mem_addr, a & ~32'h3);
        check("mem_be", mem_bus.mem_be, be);
        check("mem_wdata", mem_bus.mem_wdata, wexp);
        if (i == gd) mem_bus.mem_gnt = 1'b1;
        @(negedge clk);
        mem_bus.mem_gnt = 1'b0;
      end
      if (il) begin
        if (riw) begin
          reset = 1'b1;
          #1;
          check("rst_ctrl", {busy, done, fault, mem_bus.mem_req, mem_bus.mem_we}, 0);
          check("rst_rdata", rdata, 0);
          check("rst_addr", mem_bus.mem_addr, 0);
          check("rst_be", mem_bus.mem_be, 0);
          check("rst_wdata", mem_bus.mem_wdata, 0);
          @(negedge clk);
          reset = 1'b0; mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = rw;
          @(negedge clk);
          mem_bus.mem_rvalid = 1'b0;
          for (int i = 0; i < 4; i++) begin
            check("rst_nodone", {busy, done, mem_bus.mem_req}, 0);
            @(negedge clk);
          end
          last_rdata = 32'h0;
          return;
        end
        for (int i = 0; i < rd; i++) begin
          check("wait_noreq", mem_bus.mem_req, 0);
          if (siw && i == 0) begin
            start = 1'b1; is_load = 1'b0; is_store = 1'b1; funct3 = 3'b010; addr = 32'h5000;
          end
          @(negedge clk);
          start = 1'b0;
        end
        mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = rw;
        @(negedge clk);
        mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = $urandom;
      end
    end
    n = 0;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      check("done_timeout", done, 1);
      exp_q.delete();
    end
    if (il && !flt) last_rdata = rexp;
    @(negedge clk);
  endtask

  task automatic stray_rvalid();
    mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = $urandom;
    @(negedge clk);
    mem_bus.mem_rvalid = 1'b0;
    @(negedge clk);
    check("stray_rdata_held", rdata, last_rdata);
    check("stray_idle", {busy, done}, 0);
  endtask

  always @(negedge clk) begin
    if (done) begin
      n_txn++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", done, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("done_cycle", cyc, mon_e.done_cyc);
        check("fault", fault, mon_e.fault);
        check("busy_with_done", busy, 1);
        if (mon_e.chk_rdata) check("rdata", rdata, mon_e.rdata);
        $display("txn %0d: cycle=%0d fault=%0b rdata=%h", n_txn, cyc, fault, rdata);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] f3;
    logic [31:0] a;
    int r;
    reset = 1'b1; start = 1'b0; is_load = 1'b0; is_store = 1'b0;
    funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    mem_bus.mem_gnt = 1'b0; mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_ctrl", {busy, done, fault, mem_bus.mem_req, mem_bus.mem_we}, 0);
    check("reset_rdata", rdata, 0);
    check("reset_mem", {mem_bus.mem_addr[3:0], mem_bus.mem_be}, 0);

    access(0, 1, 3'b000, 32'h1003, 32'h000000A5, 32'h0, 0, 0, 0, 0);        // SB
    access(1, 0, 3'b000, 32'h2001, 32'h0, 32'h1234F678, 0, 0, 0, 0);        // LB
    access(1, 0, 3'b100, 32'h2001, 32'h0, 32'h1234F678, 0, 0, 0, 0);        // LBU
    access(1, 0, 3'b101, 32'h2002, 32'h0, 32'h1234F678, 1, 0, 0, 0);        // LHU
    access(1, 0, 3'b010, 32'h3000, 32'h0, 32'hCAFEBABE, 3, 1, 0, 0);        // LW slow
    access(1, 0, 3'b001, 32'h4001, 32'h0, 32'h0, 0, 0, 0, 0);               // LH misaligned
    access(0, 1, 3'b010, 32'h4002, 32'h11223344, 32'h0, 0, 0, 0, 0);        // SW misaligned
    access(0, 1, 3'b001, 32'h4002, 32'h0000BEEF, 32'h0, 2, 0, 0, 0);        // SH upper half
    access(1, 0, 3'b001, 32'h4002, 32'h0, 32'h8001_7FFF, 0, 2, 1, 0);       // LH, start in WAIT
    stray_rvalid();
    access(0, 0, 3'b010, 32'h6000, 32'h0, 32'h0, 0, 0, 0, 0);               // neither direction
    access(1, 0, 3'b010, 32'h7000, 32'h0, 32'h12345678, 0, 1, 0, 1);        // reset in WAIT
    access(1, 0, 3'b010, 32'h7004, 32'h0, 32'hA5A55A5A, 0, 0, 0, 0);        // LW after reset
    stray_rvalid();

    for (int t = 0; t < 60; t++) begin
      f3 = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
        else if (f3[0]) a[0] = 1'b0;
      end
      r = $urandom_range(0, 9);
      access(r <= 4 || r == 9, r >= 5, f3, a, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 2), 0, 0);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage behind the ALU: takes the effective address computed by the ALU (ADD of base and offset) for LB/LBU/LH/LHU/LW and SB/SH/SW, drives a word-addressed data-memory port with byte enables through a request/grant handshake, and returns sign- or zero-extended load data to the register-file writeback path. It is the consumer of the ALU's address output and the only master on the data-memory port.

## Interface
Parameters:
- WORD_SIZE, 32, data and address width (only 32 supported)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle pulse, launch access; sampled only in IDLE
- is_load  in  1  access is a load
- is_store  in  1  access is a store
- funct3  in  3  size code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  WORD_SIZE  effective byte address (ALU out)
- wdata  in  WORD_SIZE  store data, low bytes significant
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle completion pulse
- fault  out  1  valid with done: misaligned or illegal size, no memory access made
- rdata  out  WORD_SIZE  extended load data, valid with done, held until next done
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  WORD_SIZE  word address, bits [1:0] = 00
- mem_be  out  4  byte-lane enables
- mem_wdata  out  WORD_SIZE  lane-steered store data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  WORD_SIZE  read word

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: start with is_load or is_store captures addr, wdata, funct3, direction. Both set: treated as load. Neither set: start ignored.
- Check at capture: H/HU with addr[0]=1, W with addr[1:0]≠0, funct3 ∉ {000,001,010,100,101}, or store with BU/HU → fault path: go to DONE with fault=1, mem_req never asserted.
- REQ: mem_req=1, mem_we, mem_addr={addr[31:2],2'b00}, mem_be, mem_wdata held stable until mem_gnt. On gnt: store → DONE; load → WAIT.
- WAIT: on mem_rvalid, select lanes by addr[1:0], extend (B/H sign, BU/HU zero, W none), register into rdata → DONE.
- DONE: done=1 one cycle → IDLE.
- Byte enables: B → 0001 << addr[1:0]; H → 0011 << addr[1:0]; W → 1111. Store data replicated: B {4{wdata[7:0]}}, H {2{wdata[15:0]}}.
- start while busy ignored; mem_rvalid outside WAIT ignored; mem_gnt outside REQ ignored.
- Reset (any state, incl. mid-REQ/WAIT): state IDLE; busy, done, fault, mem_req, mem_we = 0; rdata, mem_addr, mem_be, mem_wdata = 0. A response arriving after reset is dropped.

## Timing
- start sampled at edge 0. Minimum latencies (zero-wait memory): store gnt in cycle 1 → done cycle 2; load gnt cycle 1, rvalid cycle 2 → done cycle 3; fault → done cycle 1.
- All outputs registered; no combinational path from mem_* inputs to outputs.
- Next start accepted in the cycle done is high? No: accepted from the cycle after done (back-to-back period = latency + 1).
- busy = state ≠ IDLE; done and busy both high in DONE.

## Structure
- Package lsu_pkg: size localparams LSU_B/H/W/BU/HU, state enum lsu_state_t, byte-enable and extension helper functions.
- Sub-module lsu_align: combinational store-lane steering plus load lane-select/extension, instanced once; FSM and registers stay in load_store_unit.

## Test plan
- SB addr=0x1003 wdata=0x000000A5, gnt immediate → mem_addr=0x1000, mem_be=1000, mem_wdata=0xA5A5A5A5, done cycle 2, fault=0.
- LB addr=0x2001, mem_rdata=0x1234F678 → rdata=0xFFFFFFF6; LBU same → 0x000000F6; LHU addr=0x2002 → 0x00001234.
- LW addr=0x3000, gnt delayed 3 cycles, rvalid 2 cycles later → mem_req/addr stable throughout REQ, done exactly one cycle after rvalid, rdata=mem_rdata.
- LH addr=0x4001 and SW addr=0x4002 → fault=1, done at cycle 1, mem_req never high.
- start pulsed during WAIT and stray mem_rvalid in IDLE → both ignored, rdata unchanged.
- reset asserted in WAIT, rvalid arrives next cycle → all outputs 0, no done; subsequent LW completes normally.
